// File: rtl/beamformer_pkg.sv
// Shared beamformer definitions.
//
// Holds the default channel-buffer geometry and the state encoding of the
// delay-configuration FSM used by beam_delay_ctrl.
//   BUFFER_SIZE     default channel buffer depth (legal delays 0..BUFFER_SIZE-1)
//   NUMBER_OF_BITS  sample width of the channel buffers
//   INDEX_WIDTH     bits needed to address one buffer entry
package beamformer_pkg;

    localparam int BUFFER_SIZE    = 8;
    localparam int NUMBER_OF_BITS = 16;
    localparam int INDEX_WIDTH    = $clog2(BUFFER_SIZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PENDING = 2'd2
    } delay_cfg_state_t;

endpackage

// File: rtl/beam_delay_ctrl_if.sv
// Serial delay-configuration bus.
//
// The three-wire bus plus channel select as seen on the pins. cfg_load frames
// one word: it rises before the first bit, stays high while cfg_sdata is
// sampled MSB first on each cfg_sclk rise, and falls after the last bit.
// cfg_sel must be stable while cfg_load is high. There is no flow control: the
// receiver always listens, and a word that arrives while a previous one is
// still pending is dropped and flagged.
//   cfg_sclk   serial bit clock (asynchronous to the system clock)
//   cfg_sdata  serial data, MSB first
//   cfg_load   word frame enable
//   cfg_sel    target channel for the word
// Modports: master drives the bus, slave (the controller) receives it.
interface beam_delay_ctrl_if #(
    parameter int SEL_WIDTH = 2
);
    logic                 cfg_sclk;
    logic                 cfg_sdata;
    logic                 cfg_load;
    logic [SEL_WIDTH-1:0] cfg_sel;

    modport master (
        output cfg_sclk,
        output cfg_sdata,
        output cfg_load,
        output cfg_sel
    );

    modport slave (
        input cfg_sclk,
        input cfg_sdata,
        input cfg_load,
        input cfg_sel
    );
endinterface

// File: rtl/beam_delay_ctrl_cfg_input_sync.sv
// Two-flop synchronizer for the asynchronous configuration pins.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset, clears both stages
//   d      asynchronous input (WIDTH bits)
//   q      synchronized output, two clk edges behind d
// A bus instance is only used for cfg_sel, which is held stable for the whole
// load window, so per-bit skew between stages never reaches the consumer.
module cfg_input_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/beam_delay_ctrl.sv
// Beamformer delay-tap configuration controller.
//
// Receives delay words over the serial configuration bus, holds an accepted
// word as pending and applies it to the selected channel's read index on the
// next frame_strobe, so delays only ever change on a frame boundary.
//
// Optional feature: define DELAY_CFG_PARITY_EN to append one even-parity bit to
// every word; words with bad parity are discarded and flagged.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-high reset
//   cfg              serial configuration bus (slave side)
//   frame_strobe     one-clk pulse at each sample-frame boundary
//   clr_error        clears cfg_error (a same-cycle new error wins)
//   read_index_flat  active delays, channel i at [i*INDEX_WIDTH +: INDEX_WIDTH]
//   commit           one-clk pulse when the pending word is applied
//   busy             high while a word is pending
//   cfg_error        sticky protocol-error flag
module beam_delay_ctrl #(
    parameter int NUM_CHANNELS = 3,
    parameter int BUFFER_SIZE  = beamformer_pkg::BUFFER_SIZE,
    parameter int INDEX_WIDTH  = $clog2(BUFFER_SIZE),
    parameter int SEL_WIDTH    = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    beam_delay_ctrl_if.slave                    cfg,
    input  logic                                frame_strobe,
    input  logic                                clr_error,
    output logic [NUM_CHANNELS*INDEX_WIDTH-1:0] read_index_flat,
    output logic                                commit,
    output logic                                busy,
    output logic                                cfg_error
);
`ifdef DELAY_CFG_PARITY_EN
    localparam int WORD_BITS = INDEX_WIDTH + 1;
`else
    localparam int WORD_BITS = INDEX_WIDTH;
`endif
    // One extra count above WORD_BITS is enough to mark an over-long word.
    localparam int CNT_W = $clog2(WORD_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_BITS + 1);

    // ------------------------------------------------------------------
    // Pin synchronization and edge detection
    // ------------------------------------------------------------------
    logic                 sclk_s;
    logic                 sdata_s;
    logic                 load_s;
    logic [SEL_WIDTH-1:0] sel_s;
    logic                 sclk_d;
    logic                 load_d;

    cfg_input_sync #(.WIDTH(1)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(cfg.cfg_sclk), .q(sclk_s)
    );
    cfg_input_sync #(.WIDTH(1)) u_sync_sdata (
        .clk(clk), .reset(reset), .d(cfg.cfg_sdata), .q(sdata_s)
    );
    cfg_input_sync #(.WIDTH(1)) u_sync_load (
        .clk(clk), .reset(reset), .d(cfg.cfg_load), .q(load_s)
    );
    cfg_input_sync #(.WIDTH(SEL_WIDTH)) u_sync_sel (
        .clk(clk), .reset(reset), .d(cfg.cfg_sel), .q(sel_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_d <= 1'b0;
            load_d <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            load_d <= load_s;
        end
    end

    // Edges are combinational on the second synchronizer stage, so the FSM
    // reacts on the third clk edge after a pin change.
    logic sclk_rise;
    logic load_rise;
    logic load_fall;

    assign sclk_rise = sclk_s & ~sclk_d;
    assign load_rise = load_s & ~load_d;
    assign load_fall = ~load_s & load_d;

    // ------------------------------------------------------------------
    // FSM and datapath state
    // ------------------------------------------------------------------
    beamformer_pkg::delay_cfg_state_t state, state_n;

    logic [CNT_W-1:0]       bit_cnt,   bit_cnt_n;
    logic [WORD_BITS-1:0]   shift_reg, shift_reg_n;
    logic [SEL_WIDTH-1:0]   sel_q,     sel_n;
    logic [INDEX_WIDTH-1:0] pend_word, pend_word_n;
    logic                   commit_n;
    logic                   err_set;

    logic [INDEX_WIDTH-1:0] chan_reg [NUM_CHANNELS];

    // Received word decode: data bits are the first INDEX_WIDTH bits shifted in.
    logic [INDEX_WIDTH-1:0] rx_data;
    logic                   parity_ok;
    logic                   sel_ok;

    assign rx_data = shift_reg[WORD_BITS-1 -: INDEX_WIDTH];
`ifdef DELAY_CFG_PARITY_EN
    // Even parity over data plus parity bit must come out zero.
    assign parity_ok = ~(^shift_reg);
`else
    assign parity_ok = 1'b1;
`endif
    assign sel_ok = 32'(sel_q) < NUM_CHANNELS;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= beamformer_pkg::IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sel_q     <= '0;
            pend_word <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_reg_n;
            sel_q     <= sel_n;
            pend_word <= pend_word_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_reg_n = shift_reg;
        sel_n       = sel_q;
        pend_word_n = pend_word;
        commit_n    = 1'b0;
        err_set     = 1'b0;

        case (state)
            beamformer_pkg::IDLE: begin
                if (load_rise) begin
                    sel_n       = sel_s;
                    bit_cnt_n   = '0;
                    shift_reg_n = '0;
                    state_n     = beamformer_pkg::SHIFT;
                end
            end

            beamformer_pkg::SHIFT: begin
                if (sclk_rise) begin
                    shift_reg_n = {shift_reg[WORD_BITS-2:0], sdata_s};
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                // A bit arriving on the same cycle as the load fall is not
                // counted toward this word; the decision uses the settled count.
                if (load_fall) begin
                    if (bit_cnt == CNT_FULL && sel_ok && parity_ok) begin
                        // Out-of-range delays are clamped, not rejected.
                        if (32'(rx_data) >= BUFFER_SIZE) begin
                            pend_word_n = INDEX_WIDTH'(BUFFER_SIZE - 1);
                        end else begin
                            pend_word_n = rx_data;
                        end
                        state_n = beamformer_pkg::PENDING;
                    end else begin
                        err_set = 1'b1;
                        state_n = beamformer_pkg::IDLE;
                    end
                end
            end

            beamformer_pkg::PENDING: begin
                if (frame_strobe) begin
                    commit_n = 1'b1;
                    // The state is leaving PENDING on this edge, so a load rise
                    // here starts a new word instead of being flagged.
                    if (load_rise) begin
                        sel_n       = sel_s;
                        bit_cnt_n   = '0;
                        shift_reg_n = '0;
                        state_n     = beamformer_pkg::SHIFT;
                    end else begin
                        state_n = beamformer_pkg::IDLE;
                    end
                end else if (load_rise) begin
                    // The intruding window is ignored: back in PENDING the FSM
                    // never looks at sclk or the load fall.
                    err_set = 1'b1;
                end
            end

            default: begin
                state_n = beamformer_pkg::IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Channel registers, commit pulse and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                chan_reg[i] <= '0;
            end
            commit    <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            commit <= commit_n;
            if (commit_n) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (sel_q == SEL_WIDTH'(i)) begin
                        chan_reg[i] <= pend_word;
                    end
                end
            end
            if (err_set) begin
                cfg_error <= 1'b1;
            end else if (clr_error) begin
                cfg_error <= 1'b0;
            end
        end
    end

    always_comb begin
        read_index_flat = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            read_index_flat[i*INDEX_WIDTH +: INDEX_WIDTH] = chan_reg[i];
        end
    end

    assign busy = (state == beamformer_pkg::PENDING);

endmodule

// File: tb/tb_beam_delay_ctrl.sv
// Directed bench for beam_delay_ctrl. A second instance with BUFFER_SIZE=6
// shares the configuration bus to exercise delay clamping.
module tb_beam_delay_ctrl;

`ifdef DELAY_CFG_PARITY_EN
    localparam int WB = 4;
`else
    localparam int WB = 3;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic frame_strobe;
    logic clr_error;

    always #5 clk = ~clk;

    beam_delay_ctrl_if #(.SEL_WIDTH(2)) cfg_bus ();

    logic [8:0] flat;
    logic       commit;
    logic       busy;
    logic       cfg_error;
    logic [8:0] flat6;
    logic       commit6;
    logic       busy6;
    logic       cfg_error6;

    beam_delay_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .cfg             (cfg_bus.slave),
        .frame_strobe    (frame_strobe),
        .clr_error       (clr_error),
        .read_index_flat (flat),
        .commit          (commit),
        .busy            (busy),
        .cfg_error       (cfg_error)
    );

    beam_delay_ctrl #(.BUFFER_SIZE(6)) dut6 (
        .clk             (clk),
        .reset           (reset),
        .cfg             (cfg_bus.slave),
        .frame_strobe    (frame_strobe),
        .clr_error       (clr_error),
        .read_index_flat (flat6),
        .commit          (commit6),
        .busy            (busy6),
        .cfg_error       (cfg_error6)
    );

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends n bits MSB first with 4-clk sclk phases. With strobe_at_fall the
    // frame strobe is placed on the cycle the controller sees the load fall.
    task automatic send_raw(input logic [1:0] sel, input logic [7:0] bits,
                            input int n, input bit strobe_at_fall);
        @(negedge clk);
        cfg_bus.cfg_sel  = sel;
        cfg_bus.cfg_load = 1'b1;
        idle_clks(4);
        for (int i = n - 1; i >= 0; i--) begin
            cfg_bus.cfg_sdata = bits[i];
            idle_clks(4);
            cfg_bus.cfg_sclk = 1'b1;
            idle_clks(4);
            cfg_bus.cfg_sclk = 1'b0;
        end
        idle_clks(4);
        cfg_bus.cfg_load = 1'b0;
        if (strobe_at_fall) begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            frame_strobe = 1'b1;
            @(posedge clk);
            #1;
            check("fall_strobe_no_commit", 32'(commit), 32'd0);
            check("fall_strobe_busy", 32'(busy), 32'd1);
            @(negedge clk);
            frame_strobe = 1'b0;
        end
        idle_clks(5);
    endtask

    task automatic send_data(input logic [1:0] sel, input logic [2:0] d);
`ifdef DELAY_CFG_PARITY_EN
        send_raw(sel, {4'b0, d, ^d}, 4, 1'b0);
`else
        send_raw(sel, {5'b0, d}, 3, 1'b0);
`endif
    endtask

    task automatic pulse_strobe(input string tag, input logic exp_commit, input logic [8:0] exp_flat);
        @(negedge clk);
        frame_strobe = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_commit"}, 32'(commit), 32'(exp_commit));
        check({tag, "_flat"}, 32'(flat), 32'(exp_flat));
        @(negedge clk);
        frame_strobe = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_commit_once"}, 32'(commit), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_error = 1'b1;
        @(negedge clk);
        clr_error = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset             = 1'b1;
        frame_strobe      = 1'b0;
        clr_error         = 1'b0;
        cfg_bus.cfg_sclk  = 1'b0;
        cfg_bus.cfg_sdata = 1'b0;
        cfg_bus.cfg_load  = 1'b0;
        cfg_bus.cfg_sel   = 2'd0;
        idle_clks(3);
        check("rst_flat", 32'(flat), 32'd0);
        check("rst_commit", 32'(commit), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(cfg_error), 32'd0);
        reset = 1'b0;
        idle_clks(2);

        // 3'b101 to channel 1: ch1 = 5, others 0.
        send_data(2'd1, 3'b101);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_error", 32'(cfg_error), 32'd0);
        pulse_strobe("t1", 1'b1, 9'd40);

        // 3'b111 to channel 0: 7 on the 8-deep build, clamped to 5 on the 6-deep one.
        send_data(2'd0, 3'b111);
        pulse_strobe("t2", 1'b1, 9'd47);
        check("t2_clamp_flat6", 32'(flat6), 32'd45);
        check("t2_clamp_error6", 32'(cfg_error6), 32'd0);

        // Short word.
        send_raw(2'd2, 8'b10, 2, 1'b0);
        check("t3a_error", 32'(cfg_error), 32'd1);
        check("t3a_busy", 32'(busy), 32'd0);
        pulse_strobe("t3a", 1'b0, 9'd47);
        pulse_clr();
        @(posedge clk); #1;
        check("t3a_clr", 32'(cfg_error), 32'd0);

        // Long word.
        send_raw(2'd2, 8'b00011, WB + 1, 1'b0);
        check("t3b_error", 32'(cfg_error), 32'd1);
        pulse_strobe("t3b", 1'b0, 9'd47);
        pulse_clr();
        @(posedge clk); #1;
        check("t3b_clr", 32'(cfg_error), 32'd0);

        // Channel select out of range.
        send_data(2'd3, 3'b001);
        check("t3c_error", 32'(cfg_error), 32'd1);
        check("t3c_busy", 32'(busy), 32'd0);
        pulse_strobe("t3c", 1'b0, 9'd47);
        pulse_clr();
        @(posedge clk); #1;
        check("t3c_clr", 32'(cfg_error), 32'd0);

        // Second load while pending: flagged, first word still commits.
        send_data(2'd2, 3'b011);
        check("t4_busy", 32'(busy), 32'd1);
        send_data(2'd0, 3'b001);
        check("t4_error", 32'(cfg_error), 32'd1);
        check("t4_still_busy", 32'(busy), 32'd1);
        pulse_strobe("t4", 1'b1, 9'd239);
        pulse_clr();

        // Load fall and strobe together: commit waits for the next strobe.
`ifdef DELAY_CFG_PARITY_EN
        send_raw(2'd1, 8'b0101, 4, 1'b1);
`else
        send_raw(2'd1, 8'b010, 3, 1'b1);
`endif
        check("t5_flat_held", 32'(flat), 32'd239);
        pulse_strobe("t5", 1'b1, 9'd215);

`ifdef DELAY_CFG_PARITY_EN
        // 3'b110 with wrong parity, then with correct parity.
        send_raw(2'd0, 8'b1101, 4, 1'b0);
        check("t6_parity_error", 32'(cfg_error), 32'd1);
        check("t6_parity_busy", 32'(busy), 32'd0);
        pulse_clr();
        send_raw(2'd0, 8'b1100, 4, 1'b0);
        check("t6_good_busy", 32'(busy), 32'd1);
        pulse_strobe("t6", 1'b1, 9'd214);
`endif

        // Reset during pending aborts the word.
        send_data(2'd0, 3'b100);
        check("t7_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_flat", 32'(flat), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_clks(2);
        pulse_strobe("t7", 1'b0, 9'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
